wshb_frame_reader: RTL and testbench

Wishbone classic master in the sys_clk domain that reads the frame buffer from SDRAM one 32-bit pixel per transaction. It pushes each pixel into the write side of the pixel FIFO, in raster order. The pixel-clock side of the video controller drains that FIFO.
Connects to the SDRAM Wishbone slave exposed by hw_support; replaces the neutralised drive of wshb_if_sdram in Top.

---
 rtl/wshb_frame_reader.sv | 118 +++++++++++
 tb/tb_wshb_frame_reader.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/wshb_frame_reader.sv
// Wishbone classic master that streams the frame buffer from SDRAM into the
// pixel FIFO, one 32-bit pixel per transaction, in raster order.
module wshb_frame_reader #(
    parameter int          HDISP    = 800,
    parameter int          VDISP    = 480,
    parameter logic [31:0] BASE_ADR = 32'h0000_0000
) (
    input  logic        sys_clk,
    input  logic        sys_rst_n,
    input  logic        enable,
    input  logic        frame_sync,
    output logic        cyc,
    output logic        stb,
    output logic        we,
    output logic [31:0] adr,
    output logic [3:0]  sel,
    output logic [2:0]  cti,
    output logic [1:0]  bte,
    output logic [31:0] dat_ms,
    input  logic [31:0] dat_sm,
    input  logic        ack,
    input  logic        err,
    output logic [31:0] fifo_wdata,
    output logic        fifo_write,
    input  logic        fifo_wfull,
    output logic        frame_done
);
    localparam int NPIX = HDISP * VDISP;
    localparam int CW   = (NPIX > 1) ? $clog2(NPIX) : 1;
    localparam logic [CW-1:0] LAST_PIX = CW'(NPIX - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        PUSH = 2'd2
    } state_t;

    state_t        state_r;
    logic [CW-1:0] count_r;
    logic          sync_pending_r;

    function automatic logic [31:0] pix_adr(input logic [CW-1:0] c);
        return BASE_ADR + (32'(c) << 2);
    endfunction

    assign we     = 1'b0;
    assign sel    = 4'hF;
    assign cti    = 3'b000;
    assign bte    = 2'b00;
    assign dat_ms = 32'h0000_0000;

    // Read sequencer: one request, one FIFO push, back to idle.
    always_ff @(posedge sys_clk) begin
        if (!sys_rst_n) begin
            state_r        <= IDLE;
            cyc            <= 1'b0;
            stb            <= 1'b0;
            adr            <= BASE_ADR;
            fifo_write     <= 1'b0;
            fifo_wdata     <= 32'h0000_0000;
            frame_done     <= 1'b0;
            count_r        <= '0;
            sync_pending_r <= 1'b0;
        end else begin
            fifo_write <= 1'b0;
            frame_done <= 1'b0;
            case (state_r)
                IDLE: begin
                    if (sync_pending_r || frame_sync) begin
                        count_r        <= '0;
                        adr            <= BASE_ADR;
                        sync_pending_r <= 1'b0;
                    end else if (enable && !fifo_wfull) begin
                        cyc     <= 1'b1;
                        stb     <= 1'b1;
                        state_r <= REQ;
                    end else begin
                        state_r <= IDLE;
                    end
                end
                REQ: begin
                    if (frame_sync) begin
                        sync_pending_r <= 1'b1;
                    end
                    // An error still produces a (zero) pixel so the raster stays aligned.
                    if (ack || err) begin
                        fifo_wdata <= ack ? dat_sm : 32'h0000_0000;
                        fifo_write <= 1'b1;
                        frame_done <= (count_r == LAST_PIX);
                        cyc        <= 1'b0;
                        stb        <= 1'b0;
                        state_r    <= PUSH;
                    end else begin
                        state_r <= REQ;
                    end
                end
                PUSH: begin
                    if (frame_sync) begin
                        sync_pending_r <= 1'b1;
                    end
                    if (count_r == LAST_PIX) begin
                        count_r <= '0;
                        adr     <= BASE_ADR;
                    end else begin
                        count_r <= count_r + CW'(1);
                        adr     <= pix_adr(count_r + CW'(1));
                    end
                    state_r <= IDLE;
                end
                default: begin
                    cyc     <= 1'b0;
                    stb     <= 1'b0;
                    state_r <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_wshb_frame_reader.sv
// Bench for wshb_frame_reader: directed vector table plus a randomized run
// checked against a transaction-level model of the frame reader.
module tb_wshb_frame_reader;
    localparam int          HDISP = 4;
    localparam int          VDISP = 2;
    localparam int          NPIX  = HDISP * VDISP;
    localparam logic [31:0] BASE  = 32'h100;

    logic        clk = 1'b0;
    logic        rst_n, enable, frame_sync, ack, err, fifo_wfull;
    logic [31:0] dat_sm;
    logic        cyc, stb, we, fifo_write, frame_done;
    logic [31:0] adr, dat_ms, fifo_wdata;
    logic [3:0]  sel;
    logic [2:0]  cti;
    logic [1:0]  bte;

    int n_chk = 0;
    int n_pass = 0;

    typedef struct {
        int          ws;
        bit          e;
        bit          sy;
        logic [31:0] d;
        logic [31:0] xadr;
        logic [31:0] xdat;
        bit          xdone;
    } vec_t;

    vec_t tbl[21];

    wshb_frame_reader #(.HDISP(HDISP), .VDISP(VDISP), .BASE_ADR(BASE)) dut (
        .sys_clk(clk), .sys_rst_n(rst_n), .enable(enable), .frame_sync(frame_sync),
        .cyc(cyc), .stb(stb), .we(we), .adr(adr), .sel(sel), .cti(cti), .bte(bte),
        .dat_ms(dat_ms), .dat_sm(dat_sm), .ack(ack), .err(err),
        .fifo_wdata(fifo_wdata), .fifo_write(fifo_write), .fifo_wfull(fifo_wfull),
        .frame_done(frame_done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", nm, act, exp);
    endtask

    function automatic vec_t mk(input int ws, input bit e, input bit sy, input logic [31:0] d,
                                input int pix, input bit xdone);
        vec_t v;
        v.ws = ws; v.e = e; v.sy = sy; v.d = d;
        v.xadr = BASE + 32'(4 * pix);
        v.xdat = e ? 32'h0 : d;
        v.xdone = xdone;
        return v;
    endfunction

    task automatic txn(input vec_t v);
        int n = 0;
        while (stb !== 1'b1 && n < 40) begin @(posedge clk); #1; n++; end
        chk("req_start", {31'b0, stb}, 32'd1);
        chk("req_adr", adr, v.xadr);
        for (int w = 0; w < v.ws; w++) begin
            @(negedge clk);
            frame_sync = (w == 0) ? v.sy : 1'b0;
            @(posedge clk); #1;
            frame_sync = 1'b0;
            chk("wait_cyc_stb", {30'b0, cyc, stb}, 32'd3);
            chk("wait_adr", adr, v.xadr);
            chk("wait_nowrite", {31'b0, fifo_write}, 32'd0);
        end
        @(negedge clk);
        frame_sync = (v.ws == 0) ? v.sy : 1'b0;
        ack = !v.e; err = v.e; dat_sm = v.d;
        @(posedge clk); #1;
        ack = 1'b0; err = 1'b0; frame_sync = 1'b0; dat_sm = $urandom;
        chk("ack_drop", {30'b0, cyc, stb}, 32'd0);
        chk("push_write", {31'b0, fifo_write}, 32'd1);
        chk("push_data", fifo_wdata, v.xdat);
        chk("push_done", {31'b0, frame_done}, {31'b0, v.xdone});
        @(posedge clk); #1;
        chk("post_write", {31'b0, fifo_write}, 32'd0);
        chk("post_done", {31'b0, frame_done}, 32'd0);
    endtask

    initial begin
        int exp_p, cur_p, wcnt, ws_cur;
        bit sync_flag, prev_stb, s_sync, s_en, s_full, s_ack, s_err, exp_wr;
        logic [31:0] s_dat, prev_adr;

        rst_n = 1'b0; enable = 1'b1; frame_sync = 1'b0; ack = 1'b0; err = 1'b0;
        fifo_wfull = 1'b0; dat_sm = 32'h0;

        for (int i = 0; i < 8; i++) tbl[i] = mk(0, 1'b0, 1'b0, 32'hA5A5_0000 + i, i, i == 7);
        for (int i = 0; i < 8; i++)
            tbl[8 + i] = mk((i == 0) ? 5 : 0, i == 3, 1'b0, 32'hB0B0_0000 + i, i, i == 7);
        for (int i = 0; i < 4; i++) tbl[16 + i] = mk(0, 1'b0, i == 3, 32'hC0C0_0000 + i, i, 1'b0);
        tbl[20] = mk(0, 1'b0, 1'b0, 32'hD00D_0000, 0, 1'b0);

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        chk("rst_cyc_stb", {30'b0, cyc, stb}, 32'd0);
        chk("rst_adr", adr, BASE);
        chk("rst_fifo", {fifo_write, frame_done, 30'b0}, 32'd0);
        chk("rst_wdata", fifo_wdata, 32'd0);
        chk("rst_consts", {we, sel, cti, bte, 22'b0}, {1'b0, 4'hF, 27'b0});
        chk("rst_datms", dat_ms, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 21; i++) txn(tbl[i]);

        // FIFO full held while idle
        fifo_wfull = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk); #1;
            chk("full_no_stb", {31'b0, stb}, 32'd0);
        end
        @(negedge clk);
        fifo_wfull = 1'b0;
        @(posedge clk); #1;
        chk("full_release_stb", {31'b0, stb}, 32'd1);
        chk("full_release_adr", adr, BASE + 32'h4);

        // Reset in the middle of a transaction, then a late ack
        @(negedge clk);
        rst_n = 1'b0;
        @(posedge clk); #1;
        chk("midrst_cyc_stb", {30'b0, cyc, stb}, 32'd0);
        chk("midrst_adr", adr, BASE);
        @(negedge clk);
        rst_n = 1'b1; enable = 1'b0; ack = 1'b1; dat_sm = 32'hDEAD_BEEF;
        @(posedge clk); #1;
        ack = 1'b0;
        chk("late_ack_nowrite", {31'b0, fifo_write}, 32'd0);
        @(posedge clk); #1;
        chk("late_ack_nowrite2", {30'b0, fifo_write, stb}, 32'd0);
        enable = 1'b1;
        txn(mk(1, 1'b0, 1'b0, 32'h1234_5678, 0, 1'b0));

        // Randomized run against the transaction-level model
        @(negedge clk);
        rst_n = 1'b0; enable = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        exp_p = 0; cur_p = 0; sync_flag = 1'b0; prev_stb = 1'b0; prev_adr = BASE;
        wcnt = 0; ws_cur = 0;
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            enable = ($urandom_range(0, 9) < 8);
            fifo_wfull = ($urandom_range(0, 9) < 2);
            frame_sync = ($urandom_range(0, 39) == 0);
            ack = 1'b0; err = 1'b0;
            if (stb) begin
                if (wcnt >= ws_cur) begin
                    if ($urandom_range(0, 9) == 0) err = 1'b1;
                    else ack = 1'b1;
                    dat_sm = $urandom;
                    wcnt = 0;
                    ws_cur = $urandom_range(0, 3);
                end else begin
                    wcnt++;
                end
            end
            s_sync = frame_sync; s_en = enable; s_full = fifo_wfull;
            s_ack = ack; s_err = err; s_dat = dat_sm;
            @(posedge clk); #1;
            chk("r_cyc_eq_stb", {31'b0, cyc}, {31'b0, stb});
            if (!prev_stb && stb) begin
                chk("r_start_allowed", {31'b0, s_en && !s_full && !s_sync}, 32'd1);
                if (sync_flag) begin exp_p = 0; sync_flag = 1'b0; end
                chk("r_start_adr", adr, BASE + 32'(4 * exp_p));
                cur_p = exp_p;
            end else if (prev_stb && stb) begin
                chk("r_adr_stable", adr, prev_adr);
            end
            exp_wr = prev_stb && (s_ack || s_err);
            chk("r_fifo_write", {31'b0, fifo_write}, {31'b0, exp_wr});
            if (exp_wr) begin
                chk("r_stb_drop", {31'b0, stb}, 32'd0);
                chk("r_wdata", fifo_wdata, s_ack ? s_dat : 32'h0);
                chk("r_frame_done", {31'b0, frame_done}, {31'b0, cur_p == NPIX - 1});
                exp_p = (cur_p + 1) % NPIX;
            end else begin
                chk("r_no_done", {31'b0, frame_done}, 32'd0);
            end
            if (s_sync) sync_flag = 1'b1;
            prev_stb = stb;
            prev_adr = adr;
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
